// File: rtl/dmem_access_unit_if.sv
// Data-memory bus bundle.
//   master (access unit): drives bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb,
//                         receives bus_ack/bus_rdata.
//   slave  (memory)     : the mirror image.
interface dmem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage data-port controller: one req/ack bus transaction per access.
// Stores get byte strobes and lane-replicated data; loads get lane extraction
// with sign/zero extension. Misaligned accesses and bus timeouts complete with
// mem_fault.
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   mem_valid, rw       access request / direction (1 = write)
//   store_sel, load_sel store width, load funct3 code
//   addr, wdata         byte address, store data (low bits)
//   busy, mem_done      in-flight flag, one-cycle completion pulse
//   mem_fault           fault flag, valid with mem_done
//   load_data           extended load result, held until next completion
//   bus                 data-memory bus (master side)
module dmem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        rw,
  input  logic [1:0]  store_sel,
  input  logic [2:0]  load_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        mem_done,
  output logic        mem_fault,
  output logic [31:0] load_data,
  dmem_access_unit_if.master bus
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  lsel_q;
  logic [1:0]  addr_lo_q;
  logic        busy_q, done_q, fault_q, req_q, we_q;
  logic [31:0] baddr_q, bwdata_q, ldata_q;
  logic [3:0]  bstrb_q;

  // ---- request decode (IDLE acceptance) ----
  logic        is_half, is_byte, misalign;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d;

  always_comb begin
    if (rw) begin
      is_half = (store_sel == 2'b01);
      is_byte = (store_sel == 2'b10);
    end else begin
      is_half = (load_sel == 3'b001) || (load_sel == 3'b101);
      is_byte = (load_sel == 3'b000) || (load_sel == 3'b100);
    end

    if (is_byte)      misalign = 1'b0;
    else if (is_half) misalign = addr[0];
    else              misalign = |addr[1:0];

    strb_d  = 4'b0000;
    wdata_d = wdata;
    if (is_byte) begin
      strb_d  = 4'b0001 << addr[1:0];
      wdata_d = {4{wdata[7:0]}};
    end else if (is_half) begin
      strb_d  = addr[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{wdata[15:0]}};
    end else begin
      strb_d  = 4'b1111;
    end
    // Reads never strobe any lane.
    if (!rw) strb_d = 4'b0000;
  end

  // ---- load lane extraction (uses the captured request) ----
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext_d;

  always_comb begin
    lane_b = bus.bus_rdata[{addr_lo_q, 3'b000} +: 8];
    lane_h = bus.bus_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    case (lsel_q)
      3'b000:  ext_d = {{24{lane_b[7]}}, lane_b};
      3'b100:  ext_d = {24'h0, lane_b};
      3'b001:  ext_d = {{16{lane_h[15]}}, lane_h};
      3'b101:  ext_d = {16'h0, lane_h};
      default: ext_d = bus.bus_rdata;
    endcase
  end

  // ---- control FSM, all outputs registered ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lsel_q    <= '0;
      addr_lo_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      baddr_q   <= '0;
      bwdata_q  <= '0;
      bstrb_q   <= '0;
      ldata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_valid) begin
            lsel_q    <= load_sel;
            addr_lo_q <= addr[1:0];
            baddr_q   <= {addr[31:2], 2'b00};
            we_q      <= rw;
            bstrb_q   <= strb_d;
            bwdata_q  <= wdata_d;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            if (misalign) begin
              // Fault straight to completion; the bus is never touched.
              state_q <= DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
        end
        REQ: begin
          // Ack is tested first so an ack in the final cycle beats the timeout.
          if (bus.bus_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            fault_q <= 1'b0;
            if (!we_q) ldata_q <= ext_d;
          end else if (cnt_q + 8'd1 == TO) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign mem_done      = done_q;
  assign mem_fault     = fault_q;
  assign load_data     = ldata_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = baddr_q;
  assign bus.bus_wdata = bwdata_q;
  assign bus.bus_wstrb = bstrb_q;

endmodule
